seven_seg_scan_controller: RTL

//  Time-multiplexes four hex digits onto the shared 7-segment decoder (BINARY/SEGMENT/DOT inputs).

---
 rtl/seven_seg_scan_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - four-digit 7-segment scan controller
// Double-buffered digit scan with commit at frame boundaries and optional leading-zero blanking.
module seven_seg_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_WIDTH   = 17,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        LOAD,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DOTS_IN,
  output logic [3:0]  BINARY,
  output logic [1:0]  SEGMENT,
  output logic        DOT,
  output logic        BLANK,
  output logic        LOAD_ACK
);

  localparam logic [CNT_WIDTH-1:0] TICK_VAL = CNT_WIDTH'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           idx;
  logic [15:0]          act_digits;
  logic [3:0]           act_dots;
  logic [15:0]          pend_digits;
  logic [3:0]           pend_dots;
  logic                 pend_valid;

  logic       tick;
  logic       commit;
  logic       lz_dark;
  logic [3:0] cur_digit;

  // The !LOAD_ACK guard keeps back-to-back IDLE loads from producing adjacent ACK pulses.
  always_comb begin
    tick      = (cnt == TICK_VAL);
    commit    = pend_valid && !LOAD_ACK &&
                ((state == IDLE) || (state == SCAN && ENABLE && tick && idx == 2'd3));
    cur_digit = act_digits[{idx, 2'b00} +: 4];
    lz_dark   = 1'b0;
    case (idx)
      2'd1:    lz_dark = (act_digits[15:4] == 12'h000);
      2'd2:    lz_dark = (act_digits[15:8] == 8'h00);
      2'd3:    lz_dark = (act_digits[15:12] == 4'h0);
      default: lz_dark = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 2'd0;
      act_digits  <= 16'h0000;
      act_dots    <= 4'h0;
      pend_digits <= 16'h0000;
      pend_dots   <= 4'h0;
      pend_valid  <= 1'b0;
      BINARY      <= 4'h0;
      SEGMENT     <= 2'd0;
      DOT         <= 1'b0;
      BLANK       <= 1'b1;
      LOAD_ACK    <= 1'b0;
    end else begin
      LOAD_ACK <= commit;
      if (commit) begin
        act_digits <= pend_digits;
        act_dots   <= pend_dots;
      end

      // A load on a commit edge stays pending; the commit moves the older contents.
      if (LOAD) begin
        pend_digits <= DIGITS_IN;
        pend_dots   <= DOTS_IN;
        pend_valid  <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end

      SEGMENT <= idx;
      BINARY  <= cur_digit;
      DOT     <= act_dots[idx];
      BLANK   <= (state != SCAN) || (LZ_BLANK && lz_dark);

      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= 2'd0;
          if (ENABLE) state <= SCAN;
        end
        SCAN: begin
          if (!ENABLE) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 2'd0;
          end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
